// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with Moore-decoded datapath controls.
// Optional macro CTRL_BNE_EN adds branch-not-equal support via a latched branch-sense bit.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_BNE   = 6'h05
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

`ifdef CTRL_BNE_EN
    localparam logic BNE_ENABLED = 1'b1;
`else
    localparam logic BNE_ENABLED = 1'b0;
`endif

    state_t state_reg;
    state_t state_next;
    state_t out_state;
    logic   opc_mem;
    logic   opc_branch;
    logic   opc_legal;
    logic   branch_cond;

    assign opc_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    assign opc_branch = (opcode == OP_BEQ) || ((opcode == OP_BNE) && BNE_ENABLED);
    assign opc_legal  = opc_mem || opc_branch || (opcode == OP_RTYPE) || (opcode == OP_J);

`ifdef CTRL_BNE_EN
    // Remembers whether the instruction in flight is BNE, captured at decode time
    logic bne_reg;
    logic bne_next;

    assign bne_next = (state_reg == DECODE) ? (opcode == OP_BNE) : bne_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bne_reg <= 1'b0;
        end else begin
            bne_reg <= bne_next;
        end
    end

    assign branch_cond = bne_reg ? ~zero : zero;
`else
    assign branch_cond = zero;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opc_mem)                 state_next = MEMADR;
                else if (opcode == OP_RTYPE) state_next = EXEC;
                else if (opc_branch)         state_next = BRANCH;
                else if (opcode == OP_J)     state_next = JUMP;
                else                         state_next = FETCH;
            end
            MEMADR: state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
            EXEC:   state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    // During reset the outputs decode as FETCH with every strobe forced low
    assign out_state = rst_n ? state_reg : FETCH;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (out_state)
            FETCH: begin
                MemRead = rst_n;
                ALUSrcB = 2'b01;
                IRWrite = rst_n & mem_ready;
                PCWrite = rst_n & mem_ready;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_en      = PCWrite | (PCWriteCond & branch_cond);
    assign illegal_op = rst_n && (state_reg == DECODE) && !opc_legal;
    assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations are queued by the
// stimulus and popped/compared on the falling edge.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;

    exp_t sb_q[$];

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] ctrl_obs;
    assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, pc_en, illegal_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cycle, obs, exp);
        end
    endtask

    // Expected control word for a state, straight from the per-state control table
    function automatic logic [17:0] spec_ctrl(input logic [3:0] st, input logic z,
                                              input logic rdy, input logic rstn,
                                              input logic ill, input logic bne);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, pce;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        if (!rstn) begin
            asb = 2'b01;
        end else begin
            case (st)
                4'd0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
                4'd1: asb = 2'b11;
                4'd2: begin asa = 1; asb = 2'b10; end
                4'd3: begin mr = 1; iord = 1; end
                4'd4: begin m2r = 1; rw = 1; end
                4'd5: begin mw = 1; iord = 1; end
                4'd6: begin asa = 1; aop = 2'b10; end
                4'd7: begin rd = 1; rw = 1; end
                4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
                4'd9: begin pcw = 1; psrc = 2'b10; end
                default: ;
            endcase
        end
        pce = pcw | (pcwc & (bne ? ~z : z));
        return {pcw, pcwc, iord, mr, mw, m2r, irw, rw, rd, asa, asb, aop, psrc, pce, ill};
    endfunction

    // Drive one cycle of stimulus and queue what must be seen during that cycle
    task automatic step(input logic [5:0] opc, input logic z, input logic rdy, input logic rstn,
                        input logic [3:0] st, input logic ill, input logic bne);
        exp_t e;
        opcode    = opc;
        zero      = z;
        mem_ready = rdy;
        rst_n     = rstn;
        e.st      = st;
        e.ctrl    = spec_ctrl(st, z, rdy, rstn, ill, bne);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cycle++;
            $display("cycle %0d: state=%0d ctrl=%05h (exp state=%0d ctrl=%05h)",
                     n_cycle, state, ctrl_obs, e.st, e.ctrl);
            check("state", {28'd0, state}, {28'd0, e.st});
            check("ctrl", {14'd0, ctrl_obs}, {14'd0, e.ctrl});
            check("mem_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset abort while stalled in MEMWR, then release into FETCH
        step(6'h2B, 0, 1, 1, 4'd0, 0, 0);
        step(6'h2B, 0, 1, 1, 4'd1, 0, 0);
        step(6'h2B, 0, 1, 1, 4'd2, 0, 0);
        step(6'h2B, 0, 0, 1, 4'd5, 0, 0);
        step(6'h2B, 0, 0, 0, 4'd5, 0, 0);
        step(6'h2B, 0, 0, 0, 4'd0, 0, 0);
        step(6'h2B, 1, 0, 1, 4'd0, 0, 0);

        // LW, no stalls
        step(6'h23, 0, 1, 1, 4'd0, 0, 0);
        step(6'h23, 0, 1, 1, 4'd1, 0, 0);
        step(6'h23, 0, 1, 1, 4'd2, 0, 0);
        step(6'h23, 0, 1, 1, 4'd3, 0, 0);
        step(6'h23, 0, 1, 1, 4'd4, 0, 0);

        // SW with three stall cycles in MEMWR
        step(6'h2B, 0, 1, 1, 4'd0, 0, 0);
        step(6'h2B, 0, 1, 1, 4'd1, 0, 0);
        step(6'h2B, 0, 1, 1, 4'd2, 0, 0);
        for (int i = 0; i < 3; i++) step(6'h2B, 0, 0, 1, 4'd5, 0, 0);
        step(6'h2B, 0, 1, 1, 4'd5, 0, 0);

        // BEQ taken then not taken
        step(6'h04, 1, 1, 1, 4'd0, 0, 0);
        step(6'h04, 1, 1, 1, 4'd1, 0, 0);
        step(6'h04, 1, 1, 1, 4'd8, 0, 0);
        step(6'h04, 0, 1, 1, 4'd0, 0, 0);
        step(6'h04, 0, 1, 1, 4'd1, 0, 0);
        step(6'h04, 0, 1, 1, 4'd8, 0, 0);

        // Illegal opcode
        step(6'h3F, 0, 1, 1, 4'd0, 0, 0);
        step(6'h3F, 0, 1, 1, 4'd1, 1, 0);

        // R-type with opcode changing after decode, then a jump
        step(6'h00, 0, 1, 1, 4'd0, 0, 0);
        step(6'h00, 0, 1, 1, 4'd1, 0, 0);
        step(6'h23, 0, 1, 1, 4'd6, 0, 0);
        step(6'h04, 0, 1, 1, 4'd7, 0, 0);
        step(6'h02, 0, 1, 1, 4'd0, 0, 0);
        step(6'h02, 0, 1, 1, 4'd1, 0, 0);
        step(6'h02, 0, 1, 1, 4'd9, 0, 0);

        // BNE with zero=0
        step(6'h05, 0, 1, 1, 4'd0, 0, 0);
`ifdef CTRL_BNE_EN
        step(6'h05, 0, 1, 1, 4'd1, 0, 0);
        step(6'h05, 0, 1, 1, 4'd8, 0, 1);
`else
        step(6'h05, 0, 1, 1, 4'd1, 1, 0);
`endif
        step(6'h00, 0, 0, 1, 4'd0, 0, 0);

        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
